// File: rtl/adc_controller.sv
// ADS1115 single-shot conversion sequencer driving a byte-level I2C engine.
// Each conversion writes the config register, waits, sets the pointer, then reads the result.
module adc_controller #(
  parameter logic [6:0]  I2C_ADDR  = 7'h48,
  parameter int unsigned CONV_WAIT = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  adcChannel,
  input  logic        adcEnable,
  output logic [15:0] adcOutputData,
  output logic        adcDataReady,
  output logic [1:0]  i2cInstruction,
  output logic        i2cEnable,
  output logic [7:0]  i2cByteToSend,
  input  logic [7:0]  i2cByteReceived,
  input  logic        i2cComplete
);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  localparam int unsigned CW = (CONV_WAIT < 2) ? 1 : $clog2(CONV_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((CONV_WAIT == 0) ? 0 : CONV_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_WAIT, S_PTR, S_RD, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    chan_q, chan_d;
  logic [7:0]    msb_q, msb_d;
  logic [7:0]    lsb_q, lsb_d;
  logic [15:0]   data_q, data_d;
  logic          rdy_q, rdy_d;

  logic [10:0]   cmd;
  logic          issuing;

  // Command table: {last step of sequence, instruction, byte}
  function automatic logic [10:0] cmd_lookup(input state_t st, input logic [2:0] step,
                                             input logic [1:0] ch);
    logic [10:0] c;
    c = {1'b1, CMD_STOP, 8'h00};
    case (st)
      S_CFG: begin
        case (step)
          3'd0:    c = {1'b0, CMD_START, 8'h00};
          3'd1:    c = {1'b0, CMD_WRITE, I2C_ADDR, 1'b0};
          3'd2:    c = {1'b0, CMD_WRITE, 8'h01};
          3'd3:    c = {1'b0, CMD_WRITE, 2'b11, ch, 4'b0011};
          3'd4:    c = {1'b0, CMD_WRITE, 8'h83};
          default: c = {1'b1, CMD_STOP, 8'h00};
        endcase
      end
      S_PTR: begin
        case (step)
          3'd0:    c = {1'b0, CMD_START, 8'h00};
          3'd1:    c = {1'b0, CMD_WRITE, I2C_ADDR, 1'b0};
          3'd2:    c = {1'b0, CMD_WRITE, 8'h00};
          default: c = {1'b1, CMD_STOP, 8'h00};
        endcase
      end
      S_RD: begin
        case (step)
          3'd0:    c = {1'b0, CMD_START, 8'h00};
          3'd1:    c = {1'b0, CMD_WRITE, I2C_ADDR, 1'b1};
          3'd2:    c = {1'b0, CMD_READ, 8'h00};
          3'd3:    c = {1'b0, CMD_READ, 8'h00};
          default: c = {1'b1, CMD_STOP, 8'h00};
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign cmd     = cmd_lookup(state_q, step_q, chan_q);
  assign issuing = ((state_q == S_CFG) || (state_q == S_PTR) || (state_q == S_RD)) && !rel_q;

  assign i2cEnable      = issuing;
  assign i2cInstruction = issuing ? cmd[9:8] : CMD_START;
  assign i2cByteToSend  = issuing ? cmd[7:0] : 8'h00;
  assign adcOutputData  = data_q;
  assign adcDataReady   = rdy_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (adcEnable) begin
          chan_d  = adcChannel;
          step_d  = 3'd0;
          rel_d   = 1'b0;
          state_d = S_CFG;
        end
      end
      S_CFG, S_PTR, S_RD: begin
        if (!rel_q) begin
          if (i2cComplete) begin
            rel_d = 1'b1;
            if (state_q == S_RD && step_q == 3'd2) msb_d = i2cByteReceived;
            if (state_q == S_RD && step_q == 3'd3) lsb_d = i2cByteReceived;
          end
        end else if (!i2cComplete) begin
          // Engine has acknowledged the drop of enable; move to the next command
          rel_d = 1'b0;
          if (cmd[10]) begin
            step_d = 3'd0;
            case (state_q)
              S_CFG: begin
                cnt_d   = '0;
                state_d = (CONV_WAIT == 0) ? S_PTR : S_WAIT;
              end
              S_PTR:   state_d = S_RD;
              default: state_d = S_DONE;
            endcase
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_PTR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        data_d = {msb_q, lsb_q};
        rdy_d  = 1'b1;
        step_d = 3'd0;
        rel_d  = 1'b0;
        if (adcEnable) begin
          chan_d  = adcChannel;
          state_d = S_CFG;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
      chan_q  <= '0;
      msb_q   <= '0;
      lsb_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_adc_controller.sv
// Directed bench for adc_controller with a behavioural I2C byte-engine model
// that logs every command it accepts.
module tb_adc_controller;

  localparam logic [1:0] T_START = 2'd0;
  localparam logic [1:0] T_STOP  = 2'd1;
  localparam logic [1:0] T_READ  = 2'd2;
  localparam logic [1:0] T_WRITE = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adcChannel = 2'd0;
  logic        adcEnable = 1'b0;
  logic [15:0] adcOutputData;
  logic        adcDataReady;
  logic [1:0]  i2cInstruction;
  logic        i2cEnable;
  logic [7:0]  i2cByteToSend;
  logic [7:0]  i2cByteReceived = 8'h00;
  logic        i2cComplete = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] rd_q[$];
  int         hold_cycles = 1;
  int         proto_err = 0;
  int         eng_st = 0;
  int         eng_cnt = 0;
  int         eng_hold = 0;
  logic [9:0] eng_cmd;

  adc_controller #(.I2C_ADDR(7'h48), .CONV_WAIT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .adcChannel      (adcChannel),
    .adcEnable       (adcEnable),
    .adcOutputData   (adcOutputData),
    .adcDataReady    (adcDataReady),
    .i2cInstruction  (i2cInstruction),
    .i2cEnable       (i2cEnable),
    .i2cByteToSend   (i2cByteToSend),
    .i2cByteReceived (i2cByteReceived),
    .i2cComplete     (i2cComplete)
  );

  always #5 clk = ~clk;

  // Engine model: accept a command, complete it after 4 cycles, hold complete hold_cycles
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_st = 0;
        i2cComplete = 1'b0;
      end else begin
        case (eng_st)
          0: begin
            if (i2cEnable) begin
              eng_cmd = {i2cInstruction, i2cByteToSend};
              log_q.push_back(eng_cmd);
              eng_cnt = 1;
              eng_st = 1;
            end
          end
          1: begin
            if (!i2cEnable || ({i2cInstruction, i2cByteToSend} !== eng_cmd)) proto_err++;
            if (eng_cnt == 4) begin
              i2cComplete = 1'b1;
              if (eng_cmd[9:8] == T_READ && rd_q.size() > 0) i2cByteReceived = rd_q.pop_front();
              else i2cByteReceived = 8'h00;
              eng_hold = 1;
              eng_st = 2;
            end else begin
              eng_cnt++;
            end
          end
          default: begin
            if (i2cEnable) proto_err++;
            if (eng_hold >= hold_cycles) begin
              i2cComplete = 1'b0;
              eng_st = 0;
            end else begin
              eng_hold++;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_conv(input logic [1:0] ch);
    exp_q.push_back({T_START, 8'h00});
    exp_q.push_back({T_WRITE, 8'h90});
    exp_q.push_back({T_WRITE, 8'h01});
    exp_q.push_back({T_WRITE, 2'b11, ch, 4'b0011});
    exp_q.push_back({T_WRITE, 8'h83});
    exp_q.push_back({T_STOP,  8'h00});
    exp_q.push_back({T_START, 8'h00});
    exp_q.push_back({T_WRITE, 8'h90});
    exp_q.push_back({T_WRITE, 8'h00});
    exp_q.push_back({T_STOP,  8'h00});
    exp_q.push_back({T_START, 8'h00});
    exp_q.push_back({T_WRITE, 8'h91});
    exp_q.push_back({T_READ,  8'h00});
    exp_q.push_back({T_READ,  8'h00});
    exp_q.push_back({T_STOP,  8'h00});
  endtask

  task automatic cmp_log(input string tag);
    int n;
    check({tag, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (i < budget && log_q.size() < n) begin
      @(negedge clk);
      i++;
    end
    check(tag, (log_q.size() >= n) ? n : log_q.size(), n);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int i;
    i = 0;
    while (i < budget && adcDataReady !== 1'b1) begin
      @(negedge clk);
      i++;
    end
    check(tag, adcDataReady, 1);
  endtask

  initial begin
    int en_hi;
    int rdy_hi;
    // Reset state, before any clock edge
    #1;
    check("rst_en",    i2cEnable, 0);
    check("rst_instr", i2cInstruction, 0);
    check("rst_byte",  i2cByteToSend, 0);
    check("rst_data",  adcOutputData, 0);
    check("rst_rdy",   adcDataReady, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Channel 0 single conversion
    rd_q = '{8'h12, 8'h34};
    exp_conv(2'd0);
    adcChannel = 2'd0;
    adcEnable = 1'b1;
    wait_log("t1_start", 1, 50);
    adcEnable = 1'b0;
    wait_ready("t1_ready", 500);
    check("t1_data", adcOutputData, 16'h1234);
    @(negedge clk);
    check("t1_rdy_pulse", adcDataReady, 0);
    check("t1_data_hold", adcOutputData, 16'h1234);
    cmp_log("t1_cmd");
    check("t1_proto", proto_err, 0);

    // Channel latching across two conversions, then disable during WAIT
    log_q.delete();
    exp_q.delete();
    rd_q = '{8'hAB, 8'hCD, 8'h55, 8'hAA};
    exp_conv(2'd3);
    exp_conv(2'd1);
    adcChannel = 2'd3;
    adcEnable = 1'b1;
    wait_log("t2_cfg_stop", 6, 100);
    repeat (10) @(negedge clk);
    adcChannel = 2'd1;
    wait_ready("t2_ready1", 500);
    check("t2_data1", adcOutputData, 16'hABCD);
    wait_log("t2_cfg2_stop", 21, 300);
    repeat (10) @(negedge clk);
    adcEnable = 1'b0;
    wait_ready("t2_ready2", 500);
    check("t2_data2", adcOutputData, 16'h55AA);
    en_hi = 0;
    rdy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i2cEnable) en_hi++;
      if (adcDataReady) rdy_hi++;
    end
    check("t2_idle_en", en_hi, 0);
    check("t2_idle_rdy", rdy_hi, 0);
    check("t2_data_hold", adcOutputData, 16'h55AA);
    cmp_log("t2_cmd");
    check("t2_proto", proto_err, 0);

    // Slow engine: complete held high three cycles
    hold_cycles = 3;
    log_q.delete();
    exp_q.delete();
    rd_q = '{8'h01, 8'h02};
    exp_conv(2'd2);
    adcChannel = 2'd2;
    adcEnable = 1'b1;
    wait_log("t3_start", 1, 50);
    adcEnable = 1'b0;
    wait_ready("t3_ready", 800);
    check("t3_data", adcOutputData, 16'h0102);
    cmp_log("t3_cmd");
    check("t3_proto", proto_err, 0);

    // Reset during the second READ
    hold_cycles = 1;
    log_q.delete();
    exp_q.delete();
    rd_q = '{8'h11, 8'h22};
    adcChannel = 2'd0;
    adcEnable = 1'b1;
    wait_log("t4_read2", 14, 300);
    check("t4_in_read2", log_q[13], {T_READ, 8'h00});
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_en",    i2cEnable, 0);
    check("t4_rst_instr", i2cInstruction, 0);
    check("t4_rst_byte",  i2cByteToSend, 0);
    check("t4_rst_data",  adcOutputData, 0);
    check("t4_rst_rdy",   adcDataReady, 0);
    repeat (2) @(negedge clk);
    log_q.delete();
    rd_q = '{8'h9A, 8'hBC};
    exp_conv(2'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_log("t4_first2", 2, 50);
    check("t4_first_start", log_q[0], {T_START, 8'h00});
    check("t4_first_addr",  log_q[1], {T_WRITE, 8'h90});
    adcEnable = 1'b0;
    wait_ready("t4_ready", 500);
    check("t4_data", adcOutputData, 16'h9ABC);
    cmp_log("t4_cmd");
    check("t4_proto", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
